alu_serial_rx: RTL

Serial command receiver for the ALU DUT. It sits directly downstream of the `sin` line driven by the testbench BFM. It collects 11-bit serial frames, assembles operands A and B and the opcode, and checks the frame count, CRC-4 and opcode. It then presents either one validated command or one error report to the ALU core.

---
 rtl/alu_serial_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_serial_rx.sv
// Serial command receiver: collects 11-bit frames on sin, assembles A/B/op,
// checks data count, CRC-4 and opcode, and emits one command or one error pulse.
module alu_serial_rx #(
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sin,
  output logic            cmd_valid,
  output logic [31:0]     a,
  output logic [31:0]     b,
  output logic [OP_W-1:0] op,
  output logic            err_valid,
  output logic [2:0]      err_flags
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t      r_state;
  logic [3:0]  r_bitcnt;
  logic [9:0]  r_shift;   // {ctl, d[7:0], stop} once bit 10 is in
  logic [63:0] r_ab;
  logic [3:0]  r_dcnt;
  logic [3:0]  r_crc;

  logic       w_ctl;
  logic [7:0] w_byte;
  logic       w_stop;
  logic [2:0] w_op;
  logic [3:0] w_rx_crc;
  logic [3:0] w_crc_data;
  logic [3:0] w_crc_cmd;
  logic       w_op_ok;
  logic [2:0] w_flags;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    crc_step = {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'b0011 : 4'b0000);
  endfunction

  // The whole byte is folded into the CRC in the CHECK cycle; equivalent to
  // feeding bits as they arrive since nothing observes the intermediate value.
  always_comb begin
    w_ctl      = r_shift[9];
    w_byte     = r_shift[8:1];
    w_stop     = r_shift[0];
    w_op       = w_byte[6:4];
    w_rx_crc   = w_byte[3:0];
    w_crc_data = r_crc;
    for (int unsigned i = 0; i < 8; i++) begin
      w_crc_data = crc_step(w_crc_data, w_byte[7-i]);
    end
    w_crc_cmd = crc_step(r_crc, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      w_crc_cmd = crc_step(w_crc_cmd, w_op[2-i]);
    end
    w_op_ok = (w_op == 3'b000) || (w_op == 3'b001) ||
              (w_op == 3'b100) || (w_op == 3'b101);
    w_flags = {(r_dcnt != 4'd8), (w_crc_cmd != w_rx_crc), !w_op_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ab      <= '0;
      r_dcnt    <= '0;
      r_crc     <= '0;
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      err_flags <= '0;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_state  <= S_RECV;
            r_bitcnt <= 4'd1;
          end
        end
        S_RECV: begin
          r_shift  <= {r_shift[8:0], sin};
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd10) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_stop) begin
            err_valid <= 1'b1;
            err_flags <= 3'b100;
            r_dcnt    <= '0;
            r_crc     <= '0;
          end else if (!w_ctl) begin
            r_ab   <= {r_ab[55:0], w_byte};
            r_dcnt <= (r_dcnt == 4'd9) ? 4'd9 : r_dcnt + 4'd1;
            r_crc  <= w_crc_data;
          end else begin
            if (w_flags == 3'b000) begin
              cmd_valid <= 1'b1;
              a         <= r_ab[63:32];
              b         <= r_ab[31:0];
              op        <= OP_W'(w_op);
            end else begin
              err_valid <= 1'b1;
              err_flags <= w_flags;
            end
            r_dcnt <= '0;
            r_crc  <= '0;
          end
          // a start bit here chains directly into the next frame
          if (!sin) begin
            r_state  <= S_RECV;
            r_bitcnt <= 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
